// File: rtl/ram_bist_ctrl.sv
// Solid-pattern march BIST for a single-port RAM with registered read data.
// Writes P, reads P, writes ~P, reads ~P over 0..DEPTH-1 and records the first mismatch.
module ram_bist_ctrl #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_en,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [7:0]            err_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR0, S_RD0, S_WR1, S_RD1, S_FLUSH, S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q;
  logic                    cmp_vld_q;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q;
  logic [DATA_WIDTH-1:0]   cmp_exp_q;
  logic                    mismatch;
  logic                    last_addr;
  logic [7:0]              err_d;

  // Read data returns one cycle after the address, so compare against the stage registers.
  always_comb begin
    mismatch  = cmp_vld_q && (ram_q != cmp_exp_q);
    last_addr = (ram_addr == LAST_ADDR);
    err_d     = err_count;
    if (mismatch && (err_count != 8'hFF)) err_d = err_count + 8'd1;
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      cmp_exp_q  <= '0;
      ram_data   <= '0;
      ram_addr   <= '0;
      ram_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
      err_count  <= '0;
    end else begin
      cmp_vld_q <= 1'b0;
      done      <= 1'b0;
      err_count <= err_d;
      // A non-zero count means the first failure is already latched.
      if (mismatch && (err_count == 8'd0)) begin
        fail_addr <= cmp_addr_q;
        fail_exp  <= cmp_exp_q;
        fail_act  <= ram_q;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_WR0;
            busy      <= 1'b1;
            ram_en    <= 1'b1;
            ram_addr  <= '0;
            ram_data  <= PATTERN;
            err_count <= '0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
          end
        end
        S_WR0: begin
          if (last_addr) begin
            state_q  <= S_RD0;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
          end else ram_addr <= ram_addr + 1'b1;
        end
        S_RD0: begin
          cmp_vld_q  <= 1'b1;
          cmp_addr_q <= ram_addr;
          cmp_exp_q  <= PATTERN;
          if (last_addr) begin
            state_q  <= S_WR1;
            ram_en   <= 1'b1;
            ram_addr <= '0;
            ram_data <= ~PATTERN;
          end else ram_addr <= ram_addr + 1'b1;
        end
        S_WR1: begin
          if (last_addr) begin
            state_q  <= S_RD1;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
          end else ram_addr <= ram_addr + 1'b1;
        end
        S_RD1: begin
          cmp_vld_q  <= 1'b1;
          cmp_addr_q <= ram_addr;
          cmp_exp_q  <= ~PATTERN;
          if (last_addr) begin
            state_q  <= S_FLUSH;
            ram_addr <= '0;
          end else ram_addr <= ram_addr + 1'b1;
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_d == 8'd0);
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with fault injection, a cycle-indexed model
// of the march, and directed runs covering clean, single-fault, saturation, reset and restart.
module tb_ram_bist_ctrl;

  localparam int         D        = 64;
  localparam int         LAST_CYC = 4 * D + 2;
  localparam logic [7:0] P        = 8'hA5;
  localparam logic [7:0] NP       = 8'h5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults ----------------
  logic [7:0] ram_data, ram_q, fail_exp, fail_act, err_count;
  logic [5:0] ram_addr, fail_addr;
  logic       ram_en, busy, done, pass;
  logic [2:0] dbg_state;

  ram_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_en(ram_en), .ram_q(ram_q),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- DUT B: 256 deep, RAM stuck at zero ----------------
  logic [7:0] ram_data_b, fail_exp_b, fail_act_b, err_count_b;
  logic [7:0] ram_addr_b, fail_addr_b;
  logic [7:0] ram_q_b = 8'h00;
  logic       ram_en_b, busy_b, done_b, pass_b;
  logic [2:0] dbg_state_b;

  ram_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .PATTERN(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .ram_data(ram_data_b), .ram_addr(ram_addr_b), .ram_en(ram_en_b), .ram_q(ram_q_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(fail_addr_b), .fail_exp(fail_exp_b), .fail_act(fail_act_b),
    .err_count(err_count_b), .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural RAM with fault modes ----------------
  // mode 0: ideal; mode 1: bit0 stuck at 0 on address 5; mode 2: q always 0
  int         fmode = 0;
  logic [7:0] mem [0:D-1];

  function automatic logic [7:0] fault(input int m, input int a, input logic [7:0] d);
    case (m)
      1:       return (a == 5) ? (d & 8'hFE) : d;
      2:       return 8'h00;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_en) mem[ram_addr] <= ram_data;
    ram_q <= fault(fmode, int'(ram_addr), mem[ram_addr]);
  end

  // ---------------- result model ----------------
  // Expected verdict of a whole run: every location holds the pattern just written,
  // the read returns it through the fault, count differences (saturating) and keep the first.
  task automatic calc(input int m, output int err, output int fa, output int fe,
                      output int fact, output bit ok);
    logic [7:0] pat, act;
    err = 0; fa = 0; fe = 0; fact = 0;
    for (int ph = 0; ph < 2; ph++) begin
      pat = (ph == 0) ? P : NP;
      for (int a = 0; a < D; a++) begin
        act = fault(m, a, pat);
        if (act != pat) begin
          if (err == 0) begin fa = a; fe = int'(pat); fact = int'(act); end
          if (err < 255) err++;
        end
      end
    end
    ok = (err == 0);
  endtask

  int run_cyc = 0;
  int exp_err, exp_fa, exp_fe, exp_fact;
  bit exp_ok;
  int hold_err = 0, hold_fa = 0, hold_fe = 0, hold_fact = 0;
  bit hold_pass = 1'b0;

  // run_cyc = index of the current cycle counted from the start edge (0 = idle)
  always @(posedge clk) begin
    if (rst) begin
      run_cyc <= 0;
      hold_err <= 0; hold_fa <= 0; hold_fe <= 0; hold_fact <= 0; hold_pass <= 1'b0;
    end else if (run_cyc == 0) begin
      if (start) begin
        run_cyc <= 1;
        hold_err <= 0; hold_fa <= 0; hold_fe <= 0; hold_fact <= 0; hold_pass <= 1'b0;
        calc(fmode, exp_err, exp_fa, exp_fe, exp_fact, exp_ok);
      end
    end else if (run_cyc == LAST_CYC) begin
      run_cyc   <= 0;
      hold_err  <= exp_err;
      hold_fa   <= exp_fa;
      hold_fe   <= exp_fe;
      hold_fact <= exp_fact;
      hold_pass <= exp_ok;
    end else begin
      run_cyc <= run_cyc + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_on = 1'b0;
  int ck_ph, ck_a, en_cnt;

  always @(negedge clk) begin
    if (chk_on) begin
      if (run_cyc >= 1 && run_cyc <= 4 * D) begin
        ck_ph = (run_cyc - 1) / D;
        ck_a  = (run_cyc - 1) % D;
        if (run_cyc == 1) en_cnt = 0;
        if (ram_en) en_cnt++;
        chk("run_ram_en", ram_en, (ck_ph == 0 || ck_ph == 2));
        chk("run_ram_addr", ram_addr, ck_a);
        if (ck_ph == 0) chk("wr0_ram_data", ram_data, P);
        if (ck_ph == 2) chk("wr1_ram_data", ram_data, NP);
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_pass", pass, 0);
        if (run_cyc == 1) chk("run_err_cleared", err_count, 0);
      end else if (run_cyc == 4 * D + 1) begin
        chk("flush_busy", busy, 1);
        chk("flush_done", done, 0);
        chk("flush_ram_en", ram_en, 0);
      end else if (run_cyc == LAST_CYC) begin
        chk("done_done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ram_en", ram_en, 0);
        chk("done_pass", pass, exp_ok);
        chk("done_err", err_count, exp_err);
        chk("done_fail_addr", fail_addr, exp_fa);
        chk("done_fail_exp", fail_exp, exp_fe);
        chk("done_fail_act", fail_act, exp_fact);
        chk("write_cycles", en_cnt, 2 * D);
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_ram_en", ram_en, 0);
        chk("idle_ram_addr", ram_addr, 0);
        chk("idle_ram_data", ram_data, 0);
        chk("idle_pass", pass, hold_pass);
        chk("idle_err", err_count, hold_err);
        chk("idle_fail_addr", fail_addr, hold_fa);
        chk("idle_fail_exp", fail_exp, hold_fe);
        chk("idle_fail_act", fail_act, hold_fact);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Pulse start and wait for done; lat is the cycle index of done (-1 on timeout/abort).
  task automatic run_a(input int restart_at, input int rst_at, output int lat);
    int k;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 1;
    lat = -1;
    while (!done && k < 400) begin
      start = (k == restart_at);
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        return;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (done) lat = k;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, k, seen;
    int m_err, m_fa, m_fe, m_fact;
    bit m_ok;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_err", err_count, 0);
    chk("rst_pass", pass, 0);
    chk("rst_b_busy", busy_b, 0);
    chk_on = 1'b1;

    // pin the model with hand-computed verdicts
    calc(1, m_err, m_fa, m_fe, m_fact, m_ok);
    chk("model_f1_err", m_err, 1);
    chk("model_f1_addr", m_fa, 5);
    chk("model_f1_exp", m_fe, 8'hA5);
    chk("model_f1_act", m_fact, 8'hA4);
    chk("model_f1_ok", m_ok, 0);
    calc(0, m_err, m_fa, m_fe, m_fact, m_ok);
    chk("model_f0_err", m_err, 0);
    chk("model_f0_ok", m_ok, 1);

    // clean run
    fmode = 0;
    run_a(0, 0, lat);
    chk("clean_latency", lat, 258);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_count, 0);
    chk("clean_fail_addr", fail_addr, 0);
    chk("clean_fail_act", fail_act, 0);
    repeat (2) @(negedge clk);

    // single stuck bit at address 5
    fmode = 1;
    run_a(0, 0, lat);
    chk("f1_latency", lat, 258);
    chk("f1_pass", pass, 0);
    chk("f1_err", err_count, 1);
    chk("f1_fail_addr", fail_addr, 5);
    chk("f1_fail_exp", fail_exp, 8'hA5);
    chk("f1_fail_act", fail_act, 8'hA4);
    repeat (2) @(negedge clk);

    // second start mid-run is ignored
    fmode = 0;
    run_a(50, 0, lat);
    chk("restart_latency", lat, 258);
    chk("restart_pass", pass, 1);
    repeat (2) @(negedge clk);

    // reset at cycle 100 of a faulty run (err_count is already 1 by then)
    fmode = 1;
    run_a(0, 100, lat);
    chk("midrst_busy", busy, 0);
    chk("midrst_ram_en", ram_en, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_done", done, 0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    fmode = 0;
    run_a(0, 0, lat);
    chk("after_rst_latency", lat, 258);
    chk("after_rst_pass", pass, 1);
    repeat (2) @(negedge clk);

    // 256-deep instance against an all-zero RAM: 512 mismatches saturate
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    k = 1;
    while (!done_b && k < 1200) begin
      @(negedge clk);
      k++;
    end
    chk("sat_latency", done_b ? k : -1, 1026);
    chk("sat_err", err_count_b, 255);
    chk("sat_pass", pass_b, 0);
    chk("sat_fail_addr", fail_addr_b, 0);
    chk("sat_fail_exp", fail_exp_b, 8'hA5);
    chk("sat_fail_act", fail_act_b, 8'h00);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary expected one");
    $fatal(1, "watchdog");
  end

endmodule
